// File: rtl/i2cmb_txn_sequencer.sv
// ---------------------------------------------------------------------------
// i2cmb_txn_sequencer
//
// Front end for the iicmb_m_wb I2C multi-bus controller. Picks one of
// NUM_REQ requesters round-robin and turns its one-byte I2C write into the
// Wishbone register accesses the controller expects:
//   SET_BUS(bus) -> START -> addr+W -> data -> STOP
// Each command is one CMDR write followed by a wait on irq_i and a CMDR read.
// The read returns DON/NAK/AL/ERR in bits 7..4 and clears the interrupt.
//
// Ports
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   req_i                per-requester request (held until its gnt_o bit)
//   addr_i/data_i/bus_i  packed per-requester slave address / byte / bus
//   gnt_o                one-hot grant, held for the whole transaction
//   done_o, status_o     one-cycle completion pulse and its status
//                        (00 OK, 01 NAK, 10 AL/ERR, 11 timeout)
//   busy_o               grant through the done_o cycle
//   cyc_o/stb_o/we_o/adr_o/dat_o, dat_i, ack_i   Wishbone master
//   irq_i                controller interrupt
//   dbg_state_o          current sequencer state
//   dbg_cmdr_o           last CMDR value read back from the controller
//
// Handshakes
//   Request side: a requester raises req_i[i] with its operands valid and
//   keeps them until it sees gnt_o[i]; operands are latched on the grant
//   edge, so anything after that is ignored. done_o[i] is the completion
//   pulse and needs no acknowledge.
//   Wishbone side: cyc/stb act as valid and ack_i as ready. adr/we/dat stay
//   stable from the cycle cyc/stb rise until ack_i is sampled high; cyc/stb
//   drop on that edge and stay low for at least one cycle. ack_i has no
//   timeout, so a slave that never acknowledges stalls the sequencer.
// ---------------------------------------------------------------------------
module i2cmb_txn_sequencer #(
  parameter int NUM_REQ        = 4,
  parameter int BUS_W          = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*7-1:0]     addr_i,
  input  logic [NUM_REQ*8-1:0]     data_i,
  input  logic [NUM_REQ*BUS_W-1:0] bus_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic [1:0]               status_o,
  output logic                     busy_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [1:0]               adr_o,
  output logic [7:0]               dat_o,
  input  logic [7:0]               dat_i,
  input  logic                     ack_i,
  input  logic                     irq_i,
  output logic [3:0]               dbg_state_o,
  output logic [7:0]               dbg_cmdr_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ADR_CSR  = 2'd0;
  localparam logic [1:0] ADR_DPR  = 2'd1;
  localparam logic [1:0] ADR_CMDR = 2'd2;
  localparam logic [7:0] CSR_ON   = 8'hC0;  // core enable + irq enable
  localparam logic [7:0] CSR_OFF  = 8'h00;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_DPR_WR, S_CMD_WR, S_WAIT_IRQ,
    S_CMD_RD, S_EVAL, S_RST0, S_RST1, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    ST_SETBUS, ST_START, ST_ADDR, ST_DATA, ST_STOP
  } step_t;

  state_t             r_state;
  step_t              r_step;
  logic [IW-1:0]      r_ptr;
  logic [TW-1:0]      r_tmo;
  logic [6:0]         r_addr;
  logic [7:0]         r_data;
  logic [BUS_W-1:0]   r_bus;
  logic [1:0]         r_status;   // running status (NAK seen)
  logic [7:0]         r_rd;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic [1:0]         r_stat_o;
  logic               r_busy;
  logic               r_cyc;
  logic               r_we;
  logic [1:0]         r_adr;
  logic [7:0]         r_dat;

  logic               w_found;
  logic [IW-1:0]      w_win;
  logic [7:0]         w_dpr;
  logic [7:0]         w_cmd;
  logic               w_don;
  logic               w_nak;
  logic               w_al_err;

  // Round-robin: first requester at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_i[(int'(r_ptr) + i) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = IW'((int'(r_ptr) + i) % NUM_REQ);
      end
    end
  end

  // DPR operand and CMDR opcode for the current command step.
  always_comb begin
    w_dpr = 8'h00;
    w_cmd = 8'h05;
    case (r_step)
      ST_SETBUS: begin w_dpr = 8'(r_bus);      w_cmd = 8'h06; end
      ST_START:  begin                          w_cmd = 8'h04; end
      ST_ADDR:   begin w_dpr = {r_addr, 1'b0}; w_cmd = 8'h01; end
      ST_DATA:   begin w_dpr = r_data;         w_cmd = 8'h01; end
      default:   begin                          w_cmd = 8'h05; end
    endcase
  end

  assign w_don    = r_rd[7];
  assign w_nak    = r_rd[6];
  assign w_al_err = r_rd[5] | r_rd[4];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_INIT;
      r_step   <= ST_SETBUS;
      r_ptr    <= '0;
      r_tmo    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_bus    <= '0;
      r_status <= '0;
      r_rd     <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_stat_o <= '0;
      r_busy   <= 1'b0;
      r_cyc    <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_dat    <= '0;
    end else begin
      // Every access state follows the same pattern: raise cyc/stb on the
      // first cycle (cyc is always low on entry, giving the idle gap), then
      // wait for ack_i and move on.
      case (r_state)
        S_INIT: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1; r_we <= 1'b1; r_adr <= ADR_CSR; r_dat <= CSR_ON;
          end else if (ack_i) begin
            r_cyc <= 1'b0; r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (w_found) begin
            r_gnt    <= NUM_REQ'(1) << w_win;
            r_busy   <= 1'b1;
            r_ptr    <= (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
            r_addr   <= addr_i[int'(w_win)*7 +: 7];
            r_data   <= data_i[int'(w_win)*8 +: 8];
            r_bus    <= bus_i[int'(w_win)*BUS_W +: BUS_W];
            r_status <= 2'b00;
            r_step   <= ST_SETBUS;
            r_state  <= S_DPR_WR;
          end
        end
        S_DPR_WR: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1; r_we <= 1'b1; r_adr <= ADR_DPR; r_dat <= w_dpr;
          end else if (ack_i) begin
            r_cyc <= 1'b0; r_state <= S_CMD_WR;
          end
        end
        S_CMD_WR: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1; r_we <= 1'b1; r_adr <= ADR_CMDR; r_dat <= w_cmd;
          end else if (ack_i) begin
            r_cyc <= 1'b0; r_tmo <= '0; r_state <= S_WAIT_IRQ;
          end
        end
        S_WAIT_IRQ: begin
          if (irq_i) begin
            r_state <= S_CMD_RD;
          end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            r_state <= S_RST0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_CMD_RD: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1; r_we <= 1'b0; r_adr <= ADR_CMDR;
          end else if (ack_i) begin
            r_cyc <= 1'b0; r_rd <= dat_i; r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          // A response with no status bit at all is treated as an error
          // rather than silently as success.
          if (w_al_err || !(w_don || w_nak)) begin
            r_stat_o <= 2'b10; r_done <= r_gnt; r_gnt <= '0; r_state <= S_DONE;
          end else begin
            case (r_step)
              ST_SETBUS: begin r_step <= ST_START; r_state <= S_CMD_WR; end
              ST_START:  begin r_step <= ST_ADDR;  r_state <= S_DPR_WR; end
              ST_ADDR, ST_DATA: begin
                if (w_nak) begin
                  r_status <= 2'b01; r_step <= ST_STOP; r_state <= S_CMD_WR;
                end else if (r_step == ST_ADDR) begin
                  r_step <= ST_DATA; r_state <= S_DPR_WR;
                end else begin
                  r_step <= ST_STOP; r_state <= S_CMD_WR;
                end
              end
              default: begin
                r_stat_o <= r_status; r_done <= r_gnt; r_gnt <= '0;
                r_state  <= S_DONE;
              end
            endcase
          end
        end
        // Timeout: pulse the core enable off and on to reset the controller.
        S_RST0: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1; r_we <= 1'b1; r_adr <= ADR_CSR; r_dat <= CSR_OFF;
          end else if (ack_i) begin
            r_cyc <= 1'b0; r_state <= S_RST1;
          end
        end
        S_RST1: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1; r_we <= 1'b1; r_adr <= ADR_CSR; r_dat <= CSR_ON;
          end else if (ack_i) begin
            r_cyc    <= 1'b0;
            r_stat_o <= 2'b11; r_done <= r_gnt; r_gnt <= '0; r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done   <= '0;
          r_stat_o <= 2'b00;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign gnt_o       = r_gnt;
  assign done_o      = r_done;
  assign status_o    = r_stat_o;
  assign busy_o      = r_busy;
  assign cyc_o       = r_cyc;
  assign stb_o       = r_cyc;
  assign we_o        = r_we;
  assign adr_o       = r_adr;
  assign dat_o       = r_dat;
  assign dbg_state_o = r_state;
  assign dbg_cmdr_o  = r_rd;

endmodule

// File: tb/tb_i2cmb_txn_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2cmb_txn_sequencer
//
// Drives i2cmb_txn_sequencer against a behavioural iicmb controller model
// (Wishbone slave with irq). The controller model:
//   - ERR on SET_BUS for any bus other than 0 (single-bus controller)
//   - NAKs addresses 0x30..0x3F
//   - NAK / AL+NAK on the data byte when enabled
//   - never raises irq when no_irq_en is set
// The expected Wishbone write list and status of each transaction come from
// a transaction-level model of the command sequence.
// ---------------------------------------------------------------------------
module tb_i2cmb_txn_sequencer;

  localparam int NR  = 4;
  localparam int BW  = 4;
  localparam int TMO = 100;

  // ---------------- clock / reset ----------------
  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [NR-1:0]    req_i;
  logic [NR*7-1:0]  addr_i;
  logic [NR*8-1:0]  data_i;
  logic [NR*BW-1:0] bus_i;
  logic [NR-1:0]    gnt_o, done_o;
  logic [1:0]       status_o;
  logic             busy_o, cyc_o, stb_o, we_o;
  logic [1:0]       adr_o;
  logic [7:0]       dat_o, dat_i;
  logic             ack_i, irq_i;
  logic [3:0]       dbg_state_o;
  logic [7:0]       dbg_cmdr_o;

  i2cmb_txn_sequencer #(.NUM_REQ(NR), .BUS_W(BW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .addr_i(addr_i),
    .data_i(data_i), .bus_i(bus_i), .gnt_o(gnt_o), .done_o(done_o),
    .status_o(status_o), .busy_o(busy_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i),
    .ack_i(ack_i), .irq_i(irq_i), .dbg_state_o(dbg_state_o),
    .dbg_cmdr_o(dbg_cmdr_o)
  );

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];   // expected {adr, dat} writes
  logic [9:0] wb_log[$];  // observed {adr, dat} writes
  int n_assert = 0;
  int n_fail   = 0;
  int done_seen = 0;

  // controller model knobs / state
  logic nak_data_en = 1'b0;
  logic al_data_en  = 1'b0;
  logic no_irq_en   = 1'b0;
  logic slow_irq_en = 1'b0;
  logic [7:0] dpr, resp, last_byte;
  int irq_cnt, ack_wait, byte_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- controller model ----------------
  task automatic slave_cmd(input logic [7:0] c);
    case (c)
      8'h06: resp = (dpr != 8'h00) ? 8'h10 : 8'h80;
      8'h04: begin resp = 8'h80; byte_idx = 0; end
      8'h01: begin
        if (byte_idx == 0) resp = (dpr[7:5] == 3'b011) ? 8'h40 : 8'h80;
        else begin
          last_byte = dpr;
          resp = al_data_en ? 8'h60 : (nak_data_en ? 8'h40 : 8'h80);
        end
        byte_idx++;
      end
      default: resp = 8'h80;
    endcase
    if (!no_irq_en) begin
      irq_cnt = slow_irq_en ? 20 : $urandom_range(0, 4);
      if (irq_cnt == 0) begin irq_i = 1'b1; irq_cnt = -1; end
    end
  endtask

  initial begin
    ack_i = 1'b0; irq_i = 1'b0; dat_i = 8'h00; dpr = 8'h00; resp = 8'h00;
    last_byte = 8'h00; irq_cnt = -1; ack_wait = 0; byte_idx = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        ack_i = 1'b0; irq_i = 1'b0; irq_cnt = -1; ack_wait = 0;
      end else begin
        if (irq_cnt > 0) begin
          irq_cnt--;
          if (irq_cnt == 0) begin irq_i = 1'b1; irq_cnt = -1; end
        end
        if (ack_i) ack_i = 1'b0;
        else if (cyc_o && stb_o) begin
          if (ack_wait > 0) ack_wait--;
          else begin
            ack_i = 1'b1;
            ack_wait = $urandom_range(0, 2);
            if (we_o) begin
              wb_log.push_back({adr_o, dat_o});
              if (adr_o == 2'd1) dpr = dat_o;
              if (adr_o == 2'd2) slave_cmd(dat_o);
            end else begin
              dat_i = (adr_o == 2'd2) ? resp : 8'h00;
              if (adr_o == 2'd2) irq_i = 1'b0;
            end
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (done_o != '0) done_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic build_exp(input logic [6:0] a, input logic [7:0] d,
                           input logic [BW-1:0] b, output logic [1:0] st);
    exp_q.delete();
    exp_q.push_back({2'd1, 8'(b)});
    exp_q.push_back({2'd2, 8'h06});
    if (no_irq_en) begin
      exp_q.push_back({2'd0, 8'h00});
      exp_q.push_back({2'd0, 8'hC0});
      st = 2'b11; return;
    end
    if (b != '0) begin st = 2'b10; return; end
    exp_q.push_back({2'd2, 8'h04});
    exp_q.push_back({2'd1, a, 1'b0});
    exp_q.push_back({2'd2, 8'h01});
    if (a[6:4] == 3'd3) begin
      exp_q.push_back({2'd2, 8'h05});
      st = 2'b01; return;
    end
    exp_q.push_back({2'd1, d});
    exp_q.push_back({2'd2, 8'h01});
    if (al_data_en) begin st = 2'b10; return; end
    exp_q.push_back({2'd2, 8'h05});
    st = nak_data_en ? 2'b01 : 2'b00;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_gnt(input string tag, output int cyc);
    cyc = 0;
    while (gnt_o == '0 && cyc < 200) begin @(negedge clk_i); cyc++; end
    check({tag, "_gnt_seen"}, 32'(gnt_o != '0), 32'd1);
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (done_o == '0 && cyc < 1000) begin @(negedge clk_i); cyc++; end
    check({tag, "_done_seen"}, 32'(done_o != '0), 32'd1);
  endtask

  task automatic wait_csr(input string tag);
    int cyc;
    cyc = 0;
    while (wb_log.size() == 0 && cyc < 50) begin @(negedge clk_i); cyc++; end
    repeat (4) @(negedge clk_i);
    check({tag, "_init_nwr"}, 32'(wb_log.size()), 32'd1);
    if (wb_log.size() > 0) check({tag, "_init_csr"}, 32'(wb_log[0]), 32'({2'd0, 8'hC0}));
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_nwr"}, 32'(wb_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wb_log.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), 32'(wb_log[i]), 32'(exp_q[i]));
  endtask

  task automatic do_txn(input int idx, input logic [6:0] a, input logic [7:0] d,
                        input logic [BW-1:0] b, input string tag);
    logic [1:0]    st;
    logic [NR-1:0] oh;
    int            cyc;
    oh = NR'(1) << idx;
    build_exp(a, d, b, st);
    wb_log.delete();
    addr_i[idx*7 +: 7] = a;
    data_i[idx*8 +: 8] = d;
    bus_i[idx*BW +: BW] = b;
    req_i = oh;
    wait_gnt(tag, cyc);
    check({tag, "_gnt"}, 32'(gnt_o), 32'(oh));
    check({tag, "_busy"}, 32'(busy_o), 32'd1);
    // Operands changing after the grant must not matter.
    req_i  = '0;
    addr_i = (NR*7)'($urandom);
    data_i = (NR*8)'($urandom);
    bus_i  = (NR*BW)'($urandom);
    wait_done(tag, cyc);
    check({tag, "_done"}, 32'(done_o), 32'(oh));
    check({tag, "_status"}, 32'(status_o), 32'(st));
    check({tag, "_gnt_clr"}, 32'(gnt_o), 32'd0);
    if (no_irq_en) check({tag, "_tmo_late"}, 32'(cyc >= TMO), 32'd1);
    @(negedge clk_i);
    check({tag, "_busy_clr"}, 32'(busy_o), 32'd0);
    check({tag, "_done_1cyc"}, 32'(done_o), 32'd0);
    compare_log(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cyc, seen, idx;
    logic [6:0] a;
    logic [7:0] d;
    logic [BW-1:0] b;
    req_i = '0; addr_i = '0; data_i = '0; bus_i = '0;

    // reset state
    repeat (3) @(negedge clk_i);
    check("rst_outs_a", 32'({gnt_o, done_o, status_o, busy_o, cyc_o, stb_o, we_o, adr_o, dat_o}), 32'd0);
    check("rst_outs_b", 32'({dbg_state_o, dbg_cmdr_o}), 32'd0);
    rst_n_i = 1'b1;
    wait_csr("boot");

    // single write, slave ACKs everything
    do_txn(0, 7'h22, 8'hA5, '0, "t1");
    check("t1_i2c_byte", 32'(last_byte), 32'hA5);

    // address NAK: no data byte, STOP issued
    do_txn(1, 7'h30, 8'h5A, '0, "t3");

    // ERR on SET_BUS, then a normal request
    do_txn(2, 7'h11, 8'h3C, BW'(5), "t4");
    do_txn(3, 7'h12, 8'h77, '0, "t4b");
    check("t4b_i2c_byte", 32'(last_byte), 32'h77);

    // data NAK, and AL+NAK on data (AL wins, no STOP)
    nak_data_en = 1'b1; do_txn(1, 7'h2A, 8'h81, '0, "nakd"); nak_data_en = 1'b0;
    al_data_en  = 1'b1; do_txn(0, 7'h2B, 8'h82, '0, "ald");  al_data_en  = 1'b0;

    // round-robin with all requesters held; pointer is at 1 after "ald"
    // so pull it back to 0 with one more transaction on slot 3.
    do_txn(3, 7'h13, 8'h99, '0, "rrpre");
    for (int s = 0; s < NR; s++) begin
      addr_i[s*7 +: 7] = 7'h40 + 7'(s);
      data_i[s*8 +: 8] = 8'h10 + 8'(s);
      bus_i[s*BW +: BW] = '0;
    end
    req_i = '1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt($sformatf("rr%0d", k), cyc);
      check($sformatf("rr%0d_gnt", k), 32'(gnt_o), 32'(1 << (k % NR)));
      if (k == 4) req_i = '0;
      wait_done($sformatf("rr%0d", k), cyc);
      check($sformatf("rr%0d_done", k), 32'(done_o), 32'(1 << (k % NR)));
      check($sformatf("rr%0d_status", k), 32'(status_o), 32'd0);
      check($sformatf("rr%0d_byte", k), 32'(last_byte), 32'(8'h10 + 8'(k % NR)));
    end
    repeat (4) @(negedge clk_i);
    check("rr_idle_gnt", 32'(gnt_o), 32'd0);

    // random transactions against the model
    for (int n = 0; n < 12; n++) begin
      idx = $urandom_range(0, NR - 1);
      a   = ($urandom_range(0, 3) == 0) ? {3'b011, 4'($urandom)} : 7'($urandom);
      d   = 8'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? BW'($urandom) : '0;
      nak_data_en = ($urandom_range(0, 3) == 0);
      al_data_en  = ($urandom_range(0, 5) == 0);
      do_txn(idx, a, d, b, $sformatf("rnd%0d", n));
    end
    nak_data_en = 1'b0; al_data_en = 1'b0;

    // irq never arrives: timeout, core reset, status 11
    no_irq_en = 1'b1; do_txn(2, 7'h21, 8'h44, '0, "t5"); no_irq_en = 1'b0;
    do_txn(1, 7'h23, 8'h45, '0, "t5b");

    // reset while waiting for the data byte irq
    wb_log.delete();
    slow_irq_en = 1'b1;
    addr_i[2*7 +: 7] = 7'h15; data_i[2*8 +: 8] = 8'h99; bus_i[2*BW +: BW] = '0;
    req_i = 4'b0100;
    cyc = 0;
    while (wb_log.size() < 7 && cyc < 500) begin @(negedge clk_i); cyc++; end
    check("t6_reach_data", 32'(wb_log.size() >= 7), 32'd1);
    repeat (3) @(negedge clk_i);
    seen = done_seen;
    #2 rst_n_i = 1'b0;
    #1;
    check("t6_rst_outs", 32'({gnt_o, done_o, status_o, busy_o, cyc_o, stb_o, we_o}), 32'd0);
    req_i = '0;
    slow_irq_en = 1'b0;
    wb_log.delete();
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    wait_csr("t6");
    check("t6_no_done", 32'(done_seen), 32'(seen));

    // pointer back at 0 after reset
    for (int s = 0; s < NR; s++) begin
      addr_i[s*7 +: 7] = 7'h50 + 7'(s);
      data_i[s*8 +: 8] = 8'h60 + 8'(s);
      bus_i[s*BW +: BW] = '0;
    end
    req_i = '1;
    wait_gnt("t6rr", cyc);
    check("t6rr_gnt", 32'(gnt_o), 32'd1);
    req_i = '0;
    wait_done("t6rr", cyc);
    check("t6rr_status", 32'(status_o), 32'd0);
    check("t6rr_byte", 32'(last_byte), 32'h60);

    repeat (3) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
